// File: rtl/enc_pkg.sv
// Shared AES/SM4 byte-transform helpers for the enc1s family of instruction units.
// SM4 S-box and linear layers exist only when ENC4S_SM4_EN is defined.
package enc_pkg;

    localparam logic [2:0] MODE_AES_E  = 3'd0;
    localparam logic [2:0] MODE_AES_EM = 3'd1;
    localparam logic [2:0] MODE_AES_D  = 3'd2;
    localparam logic [2:0] MODE_AES_DM = 3'd3;
    localparam logic [2:0] MODE_SM4_ED = 3'd4;
    localparam logic [2:0] MODE_SM4_KS = 3'd5;

    function automatic logic [7:0] gf_mul2(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul3(input logic [7:0] x);
        return gf_mul2(x) ^ x;
    endfunction

    function automatic logic [7:0] gf_mul9(input logic [7:0] x);
        return gf_mul2(gf_mul2(gf_mul2(x))) ^ x;
    endfunction

    function automatic logic [7:0] gf_mulB(input logic [7:0] x);
        return gf_mul2(gf_mul2(gf_mul2(x))) ^ gf_mul2(x) ^ x;
    endfunction

    function automatic logic [7:0] gf_mulD(input logic [7:0] x);
        return gf_mul2(gf_mul2(gf_mul2(x))) ^ gf_mul2(gf_mul2(x)) ^ x;
    endfunction

    function automatic logic [7:0] gf_mulE(input logic [7:0] x);
        return gf_mul2(gf_mul2(gf_mul2(x))) ^ gf_mul2(gf_mul2(x)) ^ gf_mul2(x);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = gf_mul2(aa);
        end
        return p;
    endfunction

    // x^254 is the multiplicative inverse in GF(2^8) and maps 0 to 0.
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] r;
        sq = x;
        r  = 8'h01;
        for (int k = 1; k < 8; k++) begin
            sq = gf_mul(sq, sq);
            r  = gf_mul(r, sq);
        end
        return r;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        logic [15:0] d;
        d = {x, x} << n;
        return d[15:8];
    endfunction

    function automatic logic [31:0] rotl32(input logic [31:0] x, input logic [4:0] sh);
        logic [63:0] d;
        d = {x, x} << sh;
        return d[63:32];
    endfunction

    function automatic logic [7:0] aes_sbox(input logic [7:0] x);
        logic [7:0] i;
        i = gf_inv(x);
        return i ^ rotl8(i, 1) ^ rotl8(i, 2) ^ rotl8(i, 3) ^ rotl8(i, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] aes_isbox(input logic [7:0] x);
        return gf_inv(rotl8(x, 1) ^ rotl8(x, 3) ^ rotl8(x, 6) ^ 8'h05);
    endfunction

`ifdef ENC4S_SM4_EN
    localparam logic [7:0] SM4_SBOX [256] = '{
        8'hd6,8'h90,8'he9,8'hfe,8'hcc,8'he1,8'h3d,8'hb7,8'h16,8'hb6,8'h14,8'hc2,8'h28,8'hfb,8'h2c,8'h05,
        8'h2b,8'h67,8'h9a,8'h76,8'h2a,8'hbe,8'h04,8'hc3,8'haa,8'h44,8'h13,8'h26,8'h49,8'h86,8'h06,8'h99,
        8'h9c,8'h42,8'h50,8'hf4,8'h91,8'hef,8'h98,8'h7a,8'h33,8'h54,8'h0b,8'h43,8'hed,8'hcf,8'hac,8'h62,
        8'he4,8'hb3,8'h1c,8'ha9,8'hc9,8'h08,8'he8,8'h95,8'h80,8'hdf,8'h94,8'hfa,8'h75,8'h8f,8'h3f,8'ha6,
        8'h47,8'h07,8'ha7,8'hfc,8'hf3,8'h73,8'h17,8'hba,8'h83,8'h59,8'h3c,8'h19,8'he6,8'h85,8'h4f,8'ha8,
        8'h68,8'h6b,8'h81,8'hb2,8'h71,8'h64,8'hda,8'h8b,8'hf8,8'heb,8'h0f,8'h4b,8'h70,8'h56,8'h9d,8'h35,
        8'h1e,8'h24,8'h0e,8'h5e,8'h63,8'h58,8'hd1,8'ha2,8'h25,8'h22,8'h7c,8'h3b,8'h01,8'h21,8'h78,8'h87,
        8'hd4,8'h00,8'h46,8'h57,8'h9f,8'hd3,8'h27,8'h52,8'h4c,8'h36,8'h02,8'he7,8'ha0,8'hc4,8'hc8,8'h9e,
        8'hea,8'hbf,8'h8a,8'hd2,8'h40,8'hc7,8'h38,8'hb5,8'ha3,8'hf7,8'hf2,8'hce,8'hf9,8'h61,8'h15,8'ha1,
        8'he0,8'hae,8'h5d,8'ha4,8'h9b,8'h34,8'h1a,8'h55,8'had,8'h93,8'h32,8'h30,8'hf5,8'h8c,8'hb1,8'he3,
        8'h1d,8'hf6,8'he2,8'h2e,8'h82,8'h66,8'hca,8'h60,8'hc0,8'h29,8'h23,8'hab,8'h0d,8'h53,8'h4e,8'h6f,
        8'hd5,8'hdb,8'h37,8'h45,8'hde,8'hfd,8'h8e,8'h2f,8'h03,8'hff,8'h6a,8'h72,8'h6d,8'h6c,8'h5b,8'h51,
        8'h8d,8'h1b,8'haf,8'h92,8'hbb,8'hdd,8'hbc,8'h7f,8'h11,8'hd9,8'h5c,8'h41,8'h1f,8'h10,8'h5a,8'hd8,
        8'h0a,8'hc1,8'h31,8'h88,8'ha5,8'hcd,8'h7b,8'hbd,8'h2d,8'h74,8'hd0,8'h12,8'hb8,8'he5,8'hb4,8'hb0,
        8'h89,8'h69,8'h97,8'h4a,8'h0c,8'h96,8'h77,8'h7e,8'h65,8'hb9,8'hf1,8'h09,8'hc5,8'h6e,8'hc6,8'h84,
        8'h18,8'hf0,8'h7d,8'hec,8'h3a,8'hdc,8'h4d,8'h20,8'h79,8'hee,8'h5f,8'h3e,8'hd7,8'hcb,8'h39,8'h48
    };

    function automatic logic [7:0] sm4_sbox(input logic [7:0] x);
        return SM4_SBOX[x];
    endfunction

    function automatic logic [31:0] sm4_l(input logic [31:0] w);
        return w ^ rotl32(w, 5'd2) ^ rotl32(w, 5'd10) ^ rotl32(w, 5'd18) ^ rotl32(w, 5'd24);
    endfunction

    function automatic logic [31:0] sm4_lk(input logic [31:0] w);
        return w ^ rotl32(w, 5'd13) ^ rotl32(w, 5'd23);
    endfunction
`endif

    function automatic logic mode_legal(input logic [2:0] mode);
`ifdef ENC4S_SM4_EN
        return mode <= MODE_SM4_KS;
`else
        return mode <= MODE_AES_DM;
`endif
    endfunction

endpackage

// File: rtl/enc_lane.sv
// One S-box lane: byte + mode -> unrotated 32-bit T(S(b)); zero for reserved modes.
// SM4 cases exist only with ENC4S_SM4_EN defined.
module enc_lane
    import enc_pkg::*;
(
    input  logic [7:0]  din_i,
    input  logic [2:0]  mode_i,
    output logic [31:0] t_o
);

    logic [7:0] s_fwd;
    logic [7:0] s_inv;

    always_comb begin
        s_fwd = aes_sbox(din_i);
        s_inv = aes_isbox(din_i);
        t_o   = 32'h0;
        case (mode_i)
            MODE_AES_E:  t_o = {24'h0, s_fwd};
            MODE_AES_EM: t_o = {gf_mul3(s_fwd), s_fwd, s_fwd, gf_mul2(s_fwd)};
            MODE_AES_D:  t_o = {24'h0, s_inv};
            MODE_AES_DM: t_o = {gf_mulB(s_inv), gf_mulD(s_inv), gf_mul9(s_inv), gf_mulE(s_inv)};
`ifdef ENC4S_SM4_EN
            MODE_SM4_ED: t_o = sm4_l({24'h0, sm4_sbox(din_i)});
            MODE_SM4_KS: t_o = sm4_lk({24'h0, sm4_sbox(din_i)});
`endif
            default:     t_o = 32'h0;
        endcase
    end

endmodule

// File: rtl/enc4s_iter.sv
// Iterative full-word AES/SM4 S-box unit: rd = rs1 ^ XOR_i rotl(T(S(rs2.byte[i])), 8*i).
// LANES bytes per RUN cycle; SM4 modes only with ENC4S_SM4_EN defined.
module enc4s_iter
    import enc_pkg::*;
#(
    parameter int LANES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] rs1,
    input  logic [31:0] rs2,
    input  logic [4:0]  fn,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] rd,
    output logic        out_ill
);

    localparam int NGRP = 4 / LANES;
    localparam logic [1:0] CNT_LAST = 2'(NGRP - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    if (!(LANES == 1 || LANES == 2 || LANES == 4)) begin : g_lanes_chk
        $error("enc4s_iter: LANES must be 1, 2 or 4");
    end

    logic [1:0]  state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [31:0] acc_q, acc_d;
    logic [31:0] rs2_q, rs2_d;
    logic [2:0]  mode_q, mode_d;
    logic        ill_q, ill_d;
    logic        accept;
    logic [31:0] grp_sum;
    logic        unused_fn;

    logic [1:0]  lane_idx [LANES];
    logic [7:0]  lane_b   [LANES];
    logic [31:0] lane_t   [LANES];

    assign unused_fn = ^fn[1:0];

    for (genvar j = 0; j < LANES; j++) begin : g_lane
        assign lane_idx[j] = 2'(int'(cnt_q) * LANES + j);
        assign lane_b[j]   = rs2_q[{lane_idx[j], 3'b000} +: 8];
        enc_lane u_lane (
            .din_i  (lane_b[j]),
            .mode_i (mode_q),
            .t_o    (lane_t[j])
        );
    end

    assign in_ready  = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);
    assign out_valid = (state_q == ST_DONE);
    assign rd        = acc_q;
    assign out_ill   = ill_q;
    assign accept    = in_valid && in_ready;

    always_comb begin
        grp_sum = 32'h0;
        for (int j = 0; j < LANES; j++) begin
            grp_sum = grp_sum ^ rotl32(lane_t[j], {lane_idx[j], 3'b000});
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        rs2_d   = rs2_q;
        mode_d  = mode_q;
        ill_d   = ill_q;
        case (state_q)
            ST_RUN: begin
                acc_d = acc_q ^ grp_sum;
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = 2'd0;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            ST_DONE: if (out_ready) state_d = ST_IDLE;
            default: ;
        endcase
        // Accept only happens in IDLE or in DONE on the pop cycle.
        if (accept) begin
            state_d = ST_RUN;
            cnt_d   = 2'd0;
            acc_d   = rs1;
            rs2_d   = rs2;
            mode_d  = fn[4:2];
            ill_d   = !mode_legal(fn[4:2]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 2'd0;
            acc_q   <= 32'h0;
            rs2_q   <= 32'h0;
            mode_q  <= 3'd0;
            ill_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            rs2_q   <= rs2_d;
            mode_q  <= mode_d;
            ill_q   <= ill_d;
        end
    end

endmodule

// File: tb/tb_enc4s_iter.sv
// Scoreboard bench for enc4s_iter: directed vectors, stall/pop+push, random ops, mid-op reset.
module tb_enc4s_iter;

    parameter int LANES = 4;
    localparam int NGRP = 4 / LANES;
`ifdef ENC4S_SM4_EN
    localparam bit SM4_EN = 1'b1;
`else
    localparam bit SM4_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] rs1 = 32'h0;
    logic [31:0] rs2 = 32'h0;
    logic [4:0]  fn = 5'h0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] rd;
    logic        out_ill;

    enc4s_iter #(.LANES(LANES)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .rs1       (rs1),
        .rs2       (rs2),
        .fn        (fn),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .rd        (rd),
        .out_ill   (out_ill)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] rd;
        logic        ill;
        int          acc_cyc;
    } exp_t;

    exp_t sbq[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    bit   rand_done = 1'b0;

    logic [7:0] aes_f [256];
    logic [7:0] aes_i [256];

    localparam logic [7:0] SM4_T [256] = '{
        8'hd6,8'h90,8'he9,8'hfe,8'hcc,8'he1,8'h3d,8'hb7,8'h16,8'hb6,8'h14,8'hc2,8'h28,8'hfb,8'h2c,8'h05,
        8'h2b,8'h67,8'h9a,8'h76,8'h2a,8'hbe,8'h04,8'hc3,8'haa,8'h44,8'h13,8'h26,8'h49,8'h86,8'h06,8'h99,
        8'h9c,8'h42,8'h50,8'hf4,8'h91,8'hef,8'h98,8'h7a,8'h33,8'h54,8'h0b,8'h43,8'hed,8'hcf,8'hac,8'h62,
        8'he4,8'hb3,8'h1c,8'ha9,8'hc9,8'h08,8'he8,8'h95,8'h80,8'hdf,8'h94,8'hfa,8'h75,8'h8f,8'h3f,8'ha6,
        8'h47,8'h07,8'ha7,8'hfc,8'hf3,8'h73,8'h17,8'hba,8'h83,8'h59,8'h3c,8'h19,8'he6,8'h85,8'h4f,8'ha8,
        8'h68,8'h6b,8'h81,8'hb2,8'h71,8'h64,8'hda,8'h8b,8'hf8,8'heb,8'h0f,8'h4b,8'h70,8'h56,8'h9d,8'h35,
        8'h1e,8'h24,8'h0e,8'h5e,8'h63,8'h58,8'hd1,8'ha2,8'h25,8'h22,8'h7c,8'h3b,8'h01,8'h21,8'h78,8'h87,
        8'hd4,8'h00,8'h46,8'h57,8'h9f,8'hd3,8'h27,8'h52,8'h4c,8'h36,8'h02,8'he7,8'ha0,8'hc4,8'hc8,8'h9e,
        8'hea,8'hbf,8'h8a,8'hd2,8'h40,8'hc7,8'h38,8'hb5,8'ha3,8'hf7,8'hf2,8'hce,8'hf9,8'h61,8'h15,8'ha1,
        8'he0,8'hae,8'h5d,8'ha4,8'h9b,8'h34,8'h1a,8'h55,8'had,8'h93,8'h32,8'h30,8'hf5,8'h8c,8'hb1,8'he3,
        8'h1d,8'hf6,8'he2,8'h2e,8'h82,8'h66,8'hca,8'h60,8'hc0,8'h29,8'h23,8'hab,8'h0d,8'h53,8'h4e,8'h6f,
        8'hd5,8'hdb,8'h37,8'h45,8'hde,8'hfd,8'h8e,8'h2f,8'h03,8'hff,8'h6a,8'h72,8'h6d,8'h6c,8'h5b,8'h51,
        8'h8d,8'h1b,8'haf,8'h92,8'hbb,8'hdd,8'hbc,8'h7f,8'h11,8'hd9,8'h5c,8'h41,8'h1f,8'h10,8'h5a,8'hd8,
        8'h0a,8'hc1,8'h31,8'h88,8'ha5,8'hcd,8'h7b,8'hbd,8'h2d,8'h74,8'hd0,8'h12,8'hb8,8'he5,8'hb4,8'hb0,
        8'h89,8'h69,8'h97,8'h4a,8'h0c,8'h96,8'h77,8'h7e,8'h65,8'hb9,8'hf1,8'h09,8'hc5,8'h6e,8'hc6,8'h84,
        8'h18,8'hf0,8'h7d,8'hec,8'h3a,8'hdc,8'h4d,8'h20,8'h79,8'hee,8'h5f,8'h3e,8'hd7,8'hcb,8'h39,8'h48
    };

    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p = 16'h0;
        for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
        for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (16'h011b << (i - 8));
        return p[7:0];
    endfunction

    function automatic logic [31:0] rot(input logic [31:0] w, input int n);
        return (w << n) | (w >> (32 - n));
    endfunction

    // Reference: whole-word result built from the per-byte definitions.
    function automatic void model(input logic [31:0] r1, input logic [31:0] r2, input logic [4:0] f,
                                  output logic [31:0] erd, output logic eill);
        logic [2:0]  m;
        logic [7:0]  b, s;
        logic [31:0] t, w;
        m    = f[4:2];
        eill = (m > 3'd5) || (m >= 3'd4 && !SM4_EN);
        erd  = r1;
        if (!eill) begin
            for (int i = 0; i < 4; i++) begin
                b = r2[8*i +: 8];
                t = 32'h0;
                case (m)
                    3'd0: t = {24'h0, aes_f[b]};
                    3'd1: begin s = aes_f[b]; t = {gm(s, 8'h03), s, s, gm(s, 8'h02)}; end
                    3'd2: t = {24'h0, aes_i[b]};
                    3'd3: begin s = aes_i[b]; t = {gm(s, 8'h0b), gm(s, 8'h0d), gm(s, 8'h09), gm(s, 8'h0e)}; end
                    3'd4: begin w = {24'h0, SM4_T[b]}; t = w ^ rot(w, 2) ^ rot(w, 10) ^ rot(w, 18) ^ rot(w, 24); end
                    3'd5: begin w = {24'h0, SM4_T[b]}; t = w ^ rot(w, 13) ^ rot(w, 23); end
                    default: t = 32'h0;
                endcase
                if (i == 0) erd = erd ^ t;
                else        erd = erd ^ rot(t, 8*i);
            end
        end
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    endtask

    task automatic fail_now(input string nm);
        n_checks++;
        $display("FAIL %s: bound expired (t=%0t)", nm, $time);
    endtask

    // Entered just after a posedge; returns just after the accept edge.
    task automatic issue(input logic [31:0] r1, input logic [31:0] r2, input logic [4:0] f,
                         input logic [31:0] erd, input logic eill, input bit discard);
        int w = 0;
        in_valid = 1'b1; rs1 = r1; rs2 = r2; fn = f;
        @(negedge clk);
        while (!in_ready && w < 200) begin @(negedge clk); w++; end
        if (!in_ready) fail_now("accept_timeout");
        else if (!discard) sbq.push_back('{erd, eill, cyc + 1});
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic issue_m(input logic [31:0] r1, input logic [31:0] r2, input logic [4:0] f);
        logic [31:0] erd;
        logic        eill;
        model(r1, r2, f, erd, eill);
        issue(r1, r2, f, erd, eill, 1'b0);
    endtask

    task automatic wait_drain();
        int w = 0;
        while (sbq.size() != 0 && w < 500) begin @(negedge clk); w++; end
        if (sbq.size() != 0) begin fail_now("drain_timeout"); sbq.delete(); end
        @(posedge clk); #1;
    endtask

    // Monitor: latency on each new result, payload on each pop.
    initial begin
        bit   mon_new = 1'b1;
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) mon_new = 1'b1;
            else if (out_valid) begin
                if (sbq.size() == 0) chk("unexpected_out_valid", {31'h0, out_valid}, 32'h0);
                else begin
                    if (mon_new) begin
                        chk("latency", cyc, sbq[0].acc_cyc + NGRP);
                        mon_new = 1'b0;
                    end
                    if (out_ready) begin
                        e = sbq.pop_front();
                        chk("rd", rd, e.rd);
                        chk("out_ill", {31'h0, out_ill}, {31'h0, e.ill});
                        mon_new = 1'b1;
                    end
                end
            end
        end
    end

    initial begin
        logic [7:0]  inv, c, s;
        logic [31:0] erd, held;
        logic        eill;
        int          w;
        bit          seen;

        c = 8'h63;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) if (gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            for (int i = 0; i < 8; i++)
                s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
            aes_f[x] = s;
        end
        for (int x = 0; x < 256; x++) aes_i[aes_f[x]] = 8'(x);

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", {31'h0, out_valid}, 32'h0);
        chk("rst_rd", rd, 32'h0);
        chk("rst_out_ill", {31'h0, out_ill}, 32'h0);
        chk("rst_in_ready", {31'h0, in_ready}, 32'h1);
        @(posedge clk); #1;

        issue(32'h0, 32'h00000000, 5'b00000, 32'h63636363, 1'b0, 1'b0);
        issue(32'h0, 32'h01010101, 5'b00000, 32'h7c7c7c7c, 1'b0, 1'b0);
        issue(32'h0, 32'h00000000, 5'b00011, 32'h63636363, 1'b0, 1'b0);
        issue(32'h0, 32'h00000000, 5'b00100, 32'h63636363, 1'b0, 1'b0);
        issue(32'h0, 32'h63636363, 5'b01000, 32'h00000000, 1'b0, 1'b0);
        issue(32'hffffffff, 32'h63636363, 5'b01000, 32'hffffffff, 1'b0, 1'b0);
        if (SM4_EN) issue(32'h0, 32'h0, 5'b10000, 32'h5b5b5b5b, 1'b0, 1'b0);
        else        issue(32'h0, 32'h0, 5'b10000, 32'h00000000, 1'b1, 1'b0);
        issue(32'h12345678, 32'hcafef00d, 5'b11100, 32'h12345678, 1'b1, 1'b0);
        wait_drain();

        // Stall in DONE for 5 cycles, then pop and push on the same edge.
        out_ready = 1'b0;
        model(32'h0badf00d, 32'h1f2e3d4c, 5'b01100, erd, eill);
        held = erd;
        issue(32'h0badf00d, 32'h1f2e3d4c, 5'b01100, erd, eill, 1'b0);
        w = 0;
        @(negedge clk);
        while (!out_valid && w < 50) begin @(negedge clk); w++; end
        if (!out_valid) fail_now("stall_wait");
        for (int k = 0; k < 5; k++) begin
            if (k > 0) @(negedge clk);
            chk("stall_rd", rd, held);
            chk("stall_in_ready", {31'h0, in_ready}, 32'h0);
            chk("stall_out_valid", {31'h0, out_valid}, 32'h1);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        issue_m(32'h55aa55aa, 32'h89abcdef, 5'b00100);
        wait_drain();

        fork
            begin
                while (!rand_done) begin
                    @(posedge clk); #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join_none
        for (int n = 0; n < 80; n++) begin
            issue_m($urandom, $urandom, 5'($urandom));
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end
        rand_done = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b1;
        wait_drain();

        // Reset during RUN: the op is dropped and no result appears.
        issue(32'hdeadbeef, 32'h01234567, 5'b11100, 32'h0, 1'b0, 1'b1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_rd", rd, 32'h0);
        chk("midrst_out_ill", {31'h0, out_ill}, 32'h0);
        chk("midrst_in_ready", {31'h0, in_ready}, 32'h1);
        seen = 1'b0;
        for (int k = 0; k < 10; k++) begin
            if (out_valid) seen = 1'b1;
            @(negedge clk);
        end
        chk("midrst_no_output", {31'h0, seen}, 32'h0);

        @(posedge clk); #1;
        issue_m(32'h0, 32'hffeeddcc, 5'b00000);
        wait_drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation bound expired");
        $fatal(1, "timeout");
    end

endmodule
